// File: rtl/gpr_pkg.sv
// Shared types and constants for the multi-port general-purpose register file.
package gpr_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } gpr_state_e;

  // Register index that is hard-wired to zero.
  localparam int ZERO_REG = 0;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NREAD      = 2;
  localparam int DEF_NWRITE     = 1;

endpackage

// File: rtl/gpr_mport_if.sv
// Decode/writeback side bundle of the register file: read, write, reserve and debug signals.
interface gpr_mport_if
  import gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NREAD      = DEF_NREAD,
  parameter int NWRITE     = DEF_NWRITE
);

  logic [NREAD*ADDR_WIDTH-1:0]  raddr;
  logic [NREAD*DATA_WIDTH-1:0]  rdata;
  logic [NREAD-1:0]             rbusy;
  logic [NWRITE-1:0]            wen;
  logic [NWRITE*ADDR_WIDTH-1:0] waddr;
  logic [NWRITE*DATA_WIDTH-1:0] wdata;
  logic                         rsv_en;
  logic [ADDR_WIDTH-1:0]        rsv_addr;
  logic [ADDR_WIDTH-1:0]        dbg_addr;
  logic [DATA_WIDTH-1:0]        dbg_data;
  logic                         ready;

  modport master (
    output raddr, wen, waddr, wdata, rsv_en, rsv_addr, dbg_addr,
    input  rdata, rbusy, dbg_data, ready
  );

  modport slave (
    input  raddr, wen, waddr, wdata, rsv_en, rsv_addr, dbg_addr,
    output rdata, rbusy, dbg_data, ready
  );

endinterface

// File: rtl/gpr_wsel.sv
// Per-read-port write match: finds the highest-numbered enabled write port targeting raddr.
module gpr_wsel
  import gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NWRITE     = DEF_NWRITE
) (
  input  logic [ADDR_WIDTH-1:0]        raddr,
  input  logic [NWRITE-1:0]            wen,
  input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
  output logic                         hit,
  output logic [DATA_WIDTH-1:0]        data
);

  // Later ports overwrite earlier matches, so the highest port index wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (raddr != ADDR_WIDTH'(ZERO_REG)) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == raddr)) begin
          hit  = 1'b1;
          data = wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/gpr_mport.sv
// Multi-port register file with write bypass, pending-write scoreboard, debug port and
// a post-reset clear sweep that zeroes every register before accepting traffic.
module gpr_mport
  import gpr_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NREAD      = DEF_NREAD,
  parameter int NWRITE     = DEF_NWRITE,
  parameter int BYPASS     = 1
) (
  input  logic      clk,
  input  logic      rst,
  gpr_mport_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZADDR = ADDR_WIDTH'(ZERO_REG);

  gpr_state_e              state, state_nx;
  logic [ADDR_WIDTH-1:0]   clr_idx, clr_idx_nx;
  logic [DATA_WIDTH-1:0]   rf [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic                    run;
  logic [NWRITE-1:0]       wen_ok;
  logic [DATA_WIDTH-1:0]   rd_arr [NREAD];
  logic [NREAD-1:0]        rb_arr;

  assign run       = (state == RUN);
  assign bus.ready = run;
  assign wen_ok    = bus.wen & {NWRITE{run}};

  // State and sweep index registers; reset restarts the sweep from index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  // Sweep sequencing: advance one register per cycle, enter RUN after the last one.
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    if (state == CLEAR) begin
      clr_idx_nx = clr_idx + 1'b1;
      if (clr_idx == ADDR_WIDTH'(DEPTH - 1)) begin
        state_nx = RUN;
      end
    end
  end

  // Register storage: zeroed by the sweep, then written by the write ports (highest port wins).
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      rf[clr_idx] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wen_ok[j] && (bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != ZADDR)) begin
          rf[bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Pending-write scoreboard: writes retire a reservation, a same-cycle reserve takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (run) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wen_ok[j] && (bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != ZADDR)) begin
          busy[bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
        end
      end
      if (bus.rsv_en && (bus.rsv_addr != ZADDR)) begin
        busy[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;
    logic [DATA_WIDTH-1:0] wd;

    assign ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

    gpr_wsel #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NWRITE     (NWRITE)
    ) u_wsel (
      .raddr (ra),
      .wen   (wen_ok),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .hit   (hit),
      .data  (wd)
    );

    // Read data and busy flag; x0 and the sweep period read as zero / not busy.
    always_comb begin
      rd_arr[i] = '0;
      rb_arr[i] = 1'b0;
      if (run && (ra != ZADDR)) begin
        if ((BYPASS != 0) && hit) begin
          rd_arr[i] = wd;
        end else begin
          rd_arr[i] = rf[ra];
        end
        if ((BYPASS != 0) && hit && !(bus.rsv_en && (bus.rsv_addr == ra))) begin
          rb_arr[i] = 1'b0;
        end else begin
          rb_arr[i] = busy[ra];
        end
      end
    end
  end

  // Flatten per-port results onto the bus.
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NREAD; i++) begin
      bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd_arr[i];
    end
  end

  assign bus.rbusy    = rb_arr;
  assign bus.dbg_data = (run && (bus.dbg_addr != ZADDR)) ? rf[bus.dbg_addr] : '0;

endmodule

// File: tb/tb_gpr_mport.sv
// Directed bench for gpr_mport: a BYPASS=1 instance and a BYPASS=0 instance share stimulus.
module tb_gpr_mport;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   cnt;

  always #5 clk = ~clk;

  gpr_mport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW)) ifa ();
  gpr_mport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW)) ifb ();

  assign ifb.raddr    = ifa.raddr;
  assign ifb.wen      = ifa.wen;
  assign ifb.waddr    = ifa.waddr;
  assign ifb.wdata    = ifa.wdata;
  assign ifb.rsv_en   = ifa.rsv_en;
  assign ifb.rsv_addr = ifa.rsv_addr;
  assign ifb.dbg_addr = ifa.dbg_addr;

  gpr_mport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  gpr_mport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR), .NWRITE(NW), .BYPASS(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.wen    = '0;
    ifa.waddr  = '0;
    ifa.wdata  = '0;
    ifa.rsv_en = 1'b0;
    ifa.rsv_addr = '0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ifa.wen[port] = 1'b1;
    ifa.waddr[port*AW +: AW] = a;
    ifa.wdata[port*DW +: DW] = d;
  endtask

  task automatic test_reset();
    logic [DW-1:0] r0, r1;
    idle();
    ifa.raddr = '0;
    ifa.dbg_addr = '0;
    rst = 1'b1;
    tick();
    total++; if (ifa.ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ifa.ready); else passed++;
    rst = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      tick();
      cnt++;
      if (ifa.ready === 1'b1) break;
    end
    total++; if (cnt !== 32) $display("FAIL sweep_len got %0d want 32", cnt); else passed++;
    total++; if (ifb.ready !== 1'b1) $display("FAIL sweep_ready_b got %b want 1", ifb.ready); else passed++;
    for (int r = 0; r < 32; r++) begin
      ifa.raddr[0 +: AW]  = AW'(r);
      ifa.raddr[AW +: AW] = AW'(31 - r);
      ifa.dbg_addr = AW'(r);
      #1;
      r0 = ifa.rdata[0 +: DW];
      r1 = ifa.rdata[DW +: DW];
      total++;
      if (r0 !== 0 || r1 !== 0 || ifa.dbg_data !== 0 || ifa.rbusy !== 0)
        $display("FAIL cleared_x%0d got r0=%h r1=%h dbg=%h busy=%b want 0", r, r0, r1, ifa.dbg_data, ifa.rbusy);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    idle();
    wr(0, 5'd5, 32'hDEADBEEF);
    wr(1, 5'd20, 32'h0000CAFE);
    tick();
    idle();
    ifa.raddr[0 +: AW]  = 5'd5;
    ifa.raddr[AW +: AW] = 5'd20;
    ifa.dbg_addr = 5'd5;
    #1;
    total++; if (ifa.rdata[0 +: DW] !== 32'hDEADBEEF) $display("FAIL rd_x5 got %h want deadbeef", ifa.rdata[0 +: DW]); else passed++;
    total++; if (ifa.rdata[DW +: DW] !== 32'h0000CAFE) $display("FAIL rd_x20 got %h want 0000cafe", ifa.rdata[DW +: DW]); else passed++;
    total++; if (ifa.dbg_data !== 32'hDEADBEEF) $display("FAIL dbg_x5 got %h want deadbeef", ifa.dbg_data); else passed++;
    wr(0, 5'd0, 32'h00001234);
    ifa.raddr[0 +: AW] = 5'd0;
    #1;
    total++; if (ifa.rdata[0 +: DW] !== 0) $display("FAIL x0_bypass got %h want 0", ifa.rdata[0 +: DW]); else passed++;
    tick();
    idle();
    ifa.raddr[AW +: AW] = 5'd0;
    ifa.dbg_addr = 5'd0;
    #1;
    total++;
    if (ifa.rdata !== 0 || ifb.rdata !== 0 || ifa.dbg_data !== 0)
      $display("FAIL x0_write got a=%h b=%h dbg=%h want 0", ifa.rdata, ifb.rdata, ifa.dbg_data);
    else passed++;
  endtask

  task automatic test_bypass();
    idle();
    wr(0, 5'd7, 32'h11111111);
    tick();
    idle();
    wr(0, 5'd7, 32'hA5A5A5A5);
    ifa.raddr[AW +: AW] = 5'd7;
    ifa.dbg_addr = 5'd7;
    #1;
    total++; if (ifa.rdata[DW +: DW] !== 32'hA5A5A5A5) $display("FAIL byp_on got %h want a5a5a5a5", ifa.rdata[DW +: DW]); else passed++;
    total++; if (ifb.rdata[DW +: DW] !== 32'h11111111) $display("FAIL byp_off got %h want 11111111", ifb.rdata[DW +: DW]); else passed++;
    total++; if (ifa.dbg_data !== 32'h11111111) $display("FAIL byp_dbg got %h want 11111111", ifa.dbg_data); else passed++;
    tick();
    idle();
    #1;
    total++; if (ifb.rdata[DW +: DW] !== 32'hA5A5A5A5) $display("FAIL byp_off_next got %h want a5a5a5a5", ifb.rdata[DW +: DW]); else passed++;
  endtask

  task automatic test_multi_write();
    idle();
    wr(0, 5'd3, 32'h00000011);
    wr(1, 5'd3, 32'h00000022);
    ifa.raddr[0 +: AW] = 5'd3;
    #1;
    total++; if (ifa.rdata[0 +: DW] !== 32'h22) $display("FAIL mw_bypass got %h want 22", ifa.rdata[0 +: DW]); else passed++;
    total++; if (ifb.rdata[0 +: DW] !== 32'h0) $display("FAIL mw_old got %h want 0", ifb.rdata[0 +: DW]); else passed++;
    tick();
    idle();
    #1;
    total++; if (ifb.rdata[0 +: DW] !== 32'h22) $display("FAIL mw_same got %h want 22", ifb.rdata[0 +: DW]); else passed++;
    wr(0, 5'd4, 32'h00000044);
    wr(1, 5'd6, 32'h00000066);
    tick();
    idle();
    ifa.raddr[0 +: AW]  = 5'd4;
    ifa.raddr[AW +: AW] = 5'd6;
    #1;
    total++;
    if (ifb.rdata[0 +: DW] !== 32'h44 || ifb.rdata[DW +: DW] !== 32'h66)
      $display("FAIL mw_split got %h/%h want 44/66", ifb.rdata[0 +: DW], ifb.rdata[DW +: DW]);
    else passed++;
  endtask

  task automatic test_scoreboard();
    idle();
    ifa.rsv_en = 1'b1;
    ifa.rsv_addr = 5'd9;
    ifa.raddr[0 +: AW]  = 5'd9;
    ifa.raddr[AW +: AW] = 5'd8;
    #1;
    total++; if (ifa.rbusy[0] !== 1'b0) $display("FAIL rsv_same_cycle got %b want 0", ifa.rbusy[0]); else passed++;
    tick();
    idle();
    #1;
    total++;
    if (ifa.rbusy !== 2'b01 || ifb.rbusy !== 2'b01)
      $display("FAIL rsv_busy got a=%b b=%b want 01", ifa.rbusy, ifb.rbusy);
    else passed++;
    wr(0, 5'd9, 32'h00000099);
    #1;
    total++; if (ifa.rbusy[0] !== 1'b0) $display("FAIL busy_byp_on got %b want 0", ifa.rbusy[0]); else passed++;
    total++; if (ifb.rbusy[0] !== 1'b1) $display("FAIL busy_byp_off got %b want 1", ifb.rbusy[0]); else passed++;
    tick();
    idle();
    #1;
    total++;
    if (ifa.rbusy[0] !== 1'b0 || ifb.rbusy[0] !== 1'b0)
      $display("FAIL busy_clear got a=%b b=%b want 0", ifa.rbusy[0], ifb.rbusy[0]);
    else passed++;
    wr(0, 5'd9, 32'h00000098);
    ifa.rsv_en = 1'b1;
    ifa.rsv_addr = 5'd9;
    tick();
    idle();
    #1;
    total++; if (ifa.rbusy[0] !== 1'b1) $display("FAIL rsv_wins got %b want 1", ifa.rbusy[0]); else passed++;
    wr(1, 5'd9, 32'h00000097);
    tick();
    idle();
    #1;
    total++; if (ifa.rbusy[0] !== 1'b0) $display("FAIL busy_clear_p1 got %b want 0", ifa.rbusy[0]); else passed++;
    ifa.rsv_en = 1'b1;
    ifa.rsv_addr = 5'd0;
    tick();
    idle();
    ifa.raddr[0 +: AW] = 5'd0;
    #1;
    total++; if (ifa.rbusy[0] !== 1'b0) $display("FAIL rsv_x0 got %b want 0", ifa.rbusy[0]); else passed++;
  endtask

  task automatic test_mid_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(0, 5'd5, 32'h0000FFFF);
    ifa.rsv_en = 1'b1;
    ifa.rsv_addr = 5'd9;
    ifa.raddr[0 +: AW]  = 5'd20;
    ifa.raddr[AW +: AW] = 5'd9;
    ifa.dbg_addr = 5'd20;
    repeat (10) tick();
    total++; if (ifa.ready !== 1'b0) $display("FAIL mid_ready got %b want 0", ifa.ready); else passed++;
    total++;
    if (ifa.rdata !== 0 || ifa.dbg_data !== 0 || ifa.rbusy !== 0)
      $display("FAIL mid_forced got rd=%h dbg=%h busy=%b want 0", ifa.rdata, ifa.dbg_data, ifa.rbusy);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    while (cnt < 100) begin
      tick();
      cnt++;
      if (ifa.ready === 1'b1) break;
    end
    idle();
    total++; if (cnt !== 32) $display("FAIL restart_len got %0d want 32", cnt); else passed++;
    ifa.raddr[0 +: AW] = 5'd5;
    #1;
    total++; if (ifa.rdata[0 +: DW] !== 0) $display("FAIL sweep_wen_ign got %h want 0", ifa.rdata[0 +: DW]); else passed++;
    total++; if (ifa.rbusy[1] !== 1'b0) $display("FAIL sweep_rsv_ign got %b want 0", ifa.rbusy[1]); else passed++;
    total++; if (ifa.dbg_data !== 0) $display("FAIL sweep_x20 got %h want 0", ifa.dbg_data); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d passed=%0d", total, passed);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_multi_write();
    test_scoreboard();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
